// File: rtl/reg_fifo_pkg.sv
// Shared constants and types for the register-file FIFO family.
package reg_fifo_pkg;
  localparam int WIDTH_DEF = 5;
  localparam int DEPTH_DEF = 8;

  // Error flag encoding shared by sibling FIFO blocks.
  typedef struct packed {
    logic ovf;
    logic udf;
  } err_t;

  localparam err_t ERR_NONE = '{ovf: 1'b0, udf: 1'b0};

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/reg_fifo_array.sv
// DEPTH x WIDTH storage: synchronous write port, combinational read port, no reset.
module reg_fifo_array #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [DEPTH-1:0][WIDTH-1:0] mem;

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/reg_fifo_buf.sv
// Register-file FIFO with registered read data driven onto a shared tristate bus.
// Optional almost_full/almost_empty outputs when REG_FIFO_BUF_ALMOST_EN is defined.
module reg_fifo_buf
  import reg_fifo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
`ifdef REG_FIFO_BUF_ALMOST_EN
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
`endif
  localparam int AW = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             rd_en,
  input  logic             oe,
  output wire logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
`ifdef REG_FIFO_BUF_ALMOST_EN
  output logic             almost_full,
  output logic             almost_empty,
`endif
  output logic             overflow,
  output logic             underflow
);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] rd_q, rdata;
  err_t             err_q;
  logic             wr_acc, rd_acc;

  // MSB of each pointer is the wrap bit; count falls out of modulo subtraction.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count = wr_ptr - rd_ptr;

  // A write at full is fine when a read frees the same slot at this edge.
  assign wr_acc = wr_en & (~full | rd_en) & ~flush;
  assign rd_acc = rd_en & ~empty & ~flush;

  reg_fifo_array #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (data_in),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rd_q   <= '0;
      err_q  <= ERR_NONE;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      err_q  <= ERR_NONE;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        rd_q   <= rdata;
      end
      if (wr_en & full & ~rd_en) err_q.ovf <= 1'b1;
      if (rd_en & empty)         err_q.udf <= 1'b1;
    end
  end

  assign overflow  = err_q.ovf;
  assign underflow = err_q.udf;
  assign data_out  = oe ? rd_q : 'z;

`ifdef REG_FIFO_BUF_ALMOST_EN
  localparam logic [AW:0] AF_CNT = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_CNT = (AW+1)'(AE_LEVEL);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);
`endif
endmodule

// File: tb/tb_reg_fifo_buf.sv
// Bench for reg_fifo_buf: queue model + read-data scoreboard, vector table, corner sequences.
module tb_reg_fifo_buf;
  localparam int W = 5;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         clear_n = 1'b0;
  logic         flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0, oe = 1'b0;
  logic [W-1:0] data_in = '0;
  wire  [W-1:0] data_bus;
  logic         full, empty, overflow, underflow;
  logic [3:0]   count;
`ifdef REG_FIFO_BUF_ALMOST_EN
  logic         almost_full, almost_empty;
`endif

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mq[$];
  logic [W-1:0] sb[$];
  logic [W-1:0] last_rd = '0;
  bit           m_ovf = 1'b0, m_udf = 1'b0;

  typedef struct {
    bit         wr;
    logic [W-1:0] din;
    bit         rd;
    logic [3:0] ecnt;
    bit         efull, eempty, eovf, eudf;
  } vec_t;
  vec_t vt[17];

  // Released bus floats high, so a driver left enabled shows up as a value change.
  pullup pu_bus (data_bus);

  always #5 clk = ~clk;

  reg_fifo_buf #(
    .WIDTH(W),
`ifdef REG_FIFO_BUF_ALMOST_EN
    .AF_LEVEL(6),
    .AE_LEVEL(2),
`endif
    .DEPTH(D)
  ) dut (
    .clk       (clk),
    .clear_n   (clear_n),
    .flush     (flush),
    .wr_en     (wr_en),
    .data_in   (data_in),
    .rd_en     (rd_en),
    .oe        (oe),
    .data_out  (data_bus),
    .full      (full),
    .empty     (empty),
    .count     (count),
`ifdef REG_FIFO_BUF_ALMOST_EN
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
`endif
    .overflow  (overflow),
    .underflow (underflow)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    sb.delete();
    last_rd = '0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".count"}, count, mq.size());
    chk({tag, ".full"}, full, mq.size() == D);
    chk({tag, ".empty"}, empty, mq.size() == 0);
    chk({tag, ".ovf"}, overflow, m_ovf);
    chk({tag, ".udf"}, underflow, m_udf);
`ifdef REG_FIFO_BUF_ALMOST_EN
    chk({tag, ".afull"}, almost_full, mq.size() >= 6);
    chk({tag, ".aempty"}, almost_empty, mq.size() <= 2);
`endif
  endtask

  // One clock of stimulus; model updated from pre-edge state, read data checked after the edge.
  task automatic drive(input bit wr, input logic [W-1:0] din, input bit rd, input bit fl);
    int n;
    logic [W-1:0] v;
    wr_en = wr; data_in = din; rd_en = rd; flush = fl;
    n = mq.size();
    if (fl) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (wr && n == D && !rd) m_ovf = 1'b1;
      if (rd && n == 0) m_udf = 1'b1;
      if (rd && n > 0) begin
        v = mq.pop_front();
        sb.push_back(v);
        last_rd = v;
      end
      if (wr && (n < D || rd)) mq.push_back(din);
    end
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
    if (sb.size() > 0) chk("rd_data", data_bus, sb.pop_front());
    else               chk("rd_hold", data_bus, last_rd);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    // vector table: fill to full, one refused write, drain
    for (int i = 0; i < 8; i++) begin
      vt[i].wr = 1'b1; vt[i].din = W'(i + 1); vt[i].rd = 1'b0;
      vt[i].ecnt = 4'(i + 1); vt[i].efull = (i == 7); vt[i].eempty = 1'b0;
      vt[i].eovf = 1'b0; vt[i].eudf = 1'b0;
    end
    vt[8].wr = 1'b1; vt[8].din = 5'h09; vt[8].rd = 1'b0;
    vt[8].ecnt = 4'd8; vt[8].efull = 1'b1; vt[8].eempty = 1'b0;
    vt[8].eovf = 1'b1; vt[8].eudf = 1'b0;
    for (int k = 0; k < 8; k++) begin
      vt[9+k].wr = 1'b0; vt[9+k].din = '0; vt[9+k].rd = 1'b1;
      vt[9+k].ecnt = 4'(7 - k); vt[9+k].efull = 1'b0; vt[9+k].eempty = (k == 7);
      vt[9+k].eovf = 1'b1; vt[9+k].eudf = 1'b0;
    end

    // reset / idle
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.count", count, 0);
    chk("rst.empty", empty, 1);
    clear_n = 1'b1;
    @(posedge clk); #1;
    chk_state("idle");
    chk("idle.hiz", data_bus, 5'h1F);
    oe = 1'b1;
    #1;
    chk("idle.oe_data", data_bus, 5'h00);

    // table-driven fill and drain
    for (int i = 0; i < 17; i++) begin
      drive(vt[i].wr, vt[i].din, vt[i].rd, 1'b0);
      chk("tbl.count", count, vt[i].ecnt);
      chk("tbl.full", full, vt[i].efull);
      chk("tbl.empty", empty, vt[i].eempty);
      chk("tbl.ovf", overflow, vt[i].eovf);
      chk("tbl.udf", underflow, vt[i].eudf);
    end
    chk("drain.last", data_bus, 5'h08);

    // wrap-around across the pointer wrap bit
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 3; k++) begin
        drive(1'b1, W'(16 + 3*r + k), 1'b0, 1'b0);
        chk("wrap.max", count <= 4'd3, 1);
      end
      for (int k = 0; k < 3; k++) drive(1'b0, '0, 1'b1, 1'b0);
      chk_state("wrap");
    end
    chk("wrap.last", data_bus, 5'h1B);

    // simultaneous read/write at full
    for (int k = 0; k < 8; k++) drive(1'b1, W'(k + 1), 1'b0, 1'b0);
    drive(1'b1, 5'h1F, 1'b1, 1'b0);
    chk_state("full_rw");
    chk("full_rw.cnt", count, 8);
    for (int k = 0; k < 8; k++) drive(1'b0, '0, 1'b1, 1'b0);
    chk("full_rw.last", data_bus, 5'h1F);

    // simultaneous read/write at empty: write only, underflow set
    drive(1'b1, 5'h0A, 1'b1, 1'b0);
    chk_state("empty_rw");
    chk("empty_rw.udf", underflow, 1);
    chk("empty_rw.cnt", count, 1);
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("empty_rw.data", data_bus, 5'h0A);

    // flush with 5 entries and overflow set; ops in the flush cycle ignored
    for (int k = 0; k < 8; k++) drive(1'b1, W'(17 + k), 1'b0, 1'b0);
    drive(1'b1, 5'h19, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) drive(1'b0, '0, 1'b1, 1'b0);
    chk_state("pre_flush");
    drive(1'b1, 5'h1C, 1'b1, 1'b1);
    chk_state("flush");
    chk("flush.hold", data_bus, 5'h13);
    drive(1'b1, 5'h07, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    chk_state("post_flush");

    // async reset in the middle of a write burst
    drive(1'b1, 5'h01, 1'b0, 1'b0);
    drive(1'b1, 5'h02, 1'b0, 1'b0);
    wr_en = 1'b1; data_in = 5'h03;
    #2 clear_n = 1'b0;
    #1;
    chk("arst.count", count, 0);
    chk("arst.empty", empty, 1);
    chk("arst.data", data_bus, 5'h00);
    @(posedge clk); #1;
    chk("arst.hold_cnt", count, 0);
    wr_en = 1'b0;
    clear_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    chk_state("arst_rel");
    drive(1'b1, 5'h15, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("arst.first", data_bus, 5'h15);
    chk_state("arst_done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
